// File: rtl/matrix_pkg.sv
// Shared types and helpers for the systolic matrix multiplier operand path.
package matrix_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // LSB position of a lane inside a packed lane bus
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DELAY-stage register chain with advance enable and synchronous clear.
// DELAY=0 is a pure pass-through; the owner's output register supplies the timing.
module skew_delay_line
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DELAY      = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_i,
    input  logic                  advance_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    generate
        if (DELAY == 0) begin : g_bypass
            logic w_unused_ctrl;
            assign w_unused_ctrl = ^{clk, reset_n, clear_i, advance_i};
            assign out_data_o    = in_data_i;
        end else begin : g_chain
            logic [DELAY-1:0][DATA_WIDTH-1:0] r_stage;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stage <= '0;
                end else if (clear_i) begin
                    r_stage <= '0;
                end else if (advance_i) begin
                    r_stage[0] <= in_data_i;
                    for (int j = 1; j < int'(DELAY); j++) begin
                        r_stage[j] <= r_stage[j-1];
                    end
                end
            end

            assign out_data_o = r_stage[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/matrix_skew_feeder.sv
// Re-times K operand vectors into N diagonally skewed lanes plus N-1 zero flush steps.
// Optional stall counter output enabled by MATRIX_SKEW_FEEDER_STALL_CNT_EN.
module matrix_skew_feeder
    import matrix_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int unsigned N          = 4,
    parameter  int unsigned K_MAX      = 16,
    localparam int unsigned KW         = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_i,
    input  logic [KW-1:0]           k_len_i,
    input  logic [N*DATA_WIDTH-1:0] in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [N*DATA_WIDTH-1:0] lane_data_o,
    output logic                    shift_o,
    output logic                    busy_o,
    output logic                    done_o
`ifdef MATRIX_SKEW_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt_o
`endif
);

    localparam int unsigned SW = $clog2(K_MAX + N);
    localparam int unsigned BW = N * DATA_WIDTH;

    feeder_state_t   r_state;
    feeder_state_t   w_state_nxt;
    logic [KW-1:0]   r_k;
    logic [SW-1:0]   r_step;
    logic            r_shift;
    logic            r_busy;
    logic            r_done;
    logic [BW-1:0]   r_lane;

    logic            w_advance;
    logic            w_clear;
    logic            w_start_acc;
    logic [KW-1:0]   w_k_eff;
    logic [SW-1:0]   w_step_inc;
    logic [BW-1:0]   w_feed;
    logic [BW-1:0]   w_lane_nxt;

    assign w_k_eff    = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
    assign w_step_inc = r_step + SW'(1);
    assign w_feed     = (r_state == LOAD) ? in_data_i : '0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and step control; r_busy gate keeps start ignored during the done pulse
    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_clear     = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i && !r_busy) begin
                    w_start_acc = 1'b1;
                    if (w_k_eff == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_clear     = 1'b1;
                        w_state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_valid_i) begin
                    w_advance = 1'b1;
                    if (w_step_inc == SW'(r_k)) begin
                        w_state_nxt = (N > 1) ? DRAIN : DONE;
                    end
                end
            end
            DRAIN: begin
                w_advance = 1'b1;
                if (w_step_inc == SW'(r_k) + SW'(N - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Done pulse trails the DONE state so it lands after the final shift pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k     <= '0;
            r_step  <= '0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lane  <= '0;
        end else begin
            r_shift <= w_advance;
            r_busy  <= (w_state_nxt != IDLE) || (r_state == DONE);
            r_done  <= (r_state == DONE);
            if (w_start_acc) begin
                r_k    <= w_k_eff;
                r_step <= '0;
            end else if (w_advance) begin
                r_step <= w_step_inc;
            end
            if (w_advance) begin
                r_lane <= w_lane_nxt;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < int'(N); gi++) begin : g_lane
            localparam int unsigned LSB = lane_lsb(gi, DATA_WIDTH);
            logic [DATA_WIDTH-1:0] w_tap;

            skew_delay_line #(
                .DATA_WIDTH (DATA_WIDTH),
                .DELAY      (gi)
            ) u_delay (
                .clk        (clk),
                .reset_n    (reset_n),
                .clear_i    (w_clear),
                .advance_i  (w_advance),
                .in_data_i  (w_feed[LSB +: DATA_WIDTH]),
                .out_data_o (w_tap)
            );

            assign w_lane_nxt[LSB +: DATA_WIDTH] = w_tap;
        end
    endgenerate

`ifdef MATRIX_SKEW_FEEDER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of LOAD cycles without an offered vector
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == LOAD) && !in_valid_i && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

    assign in_ready_o  = (r_state == LOAD);
    assign lane_data_o = r_lane;
    assign shift_o     = r_shift;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// Directed self-checking bench for matrix_skew_feeder (N=4 and N=1 instances).
module tb_matrix_skew_feeder;

    localparam int unsigned KW = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [KW-1:0] k_len_i;
    logic [31:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] lane_data_o;
    logic        shift_o;
    logic        busy_o;
    logic        done_o;

    logic        start1;
    logic [KW-1:0] k1;
    logic [7:0]  data1;
    logic        valid1;
    logic        ready1;
    logic [7:0]  lane1;
    logic        shift1;
    logic        busy1;
    logic        done1;

`ifdef MATRIX_SKEW_FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
    logic [15:0] stall1;
`endif

    always #5 clk = ~clk;

    matrix_skew_feeder #(.DATA_WIDTH(8), .N(4), .K_MAX(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_i),
        .k_len_i     (k_len_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .lane_data_o (lane_data_o),
        .shift_o     (shift_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef MATRIX_SKEW_FEEDER_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    matrix_skew_feeder #(.DATA_WIDTH(8), .N(1), .K_MAX(16)) dut1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start1),
        .k_len_i     (k1),
        .in_data_i   (data1),
        .in_valid_i  (valid1),
        .in_ready_o  (ready1),
        .lane_data_o (lane1),
        .shift_o     (shift1),
        .busy_o      (busy1),
        .done_o      (done1)
`ifdef MATRIX_SKEW_FEEDER_STALL_CNT_EN
        ,
        .stall_cnt_o (stall1)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [31:0] q_lane[$];
    int          q_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [7:0]  q1_lane[$];
    int          q1_cyc[$];
    int          done1_cnt = 0;
    int          done1_cyc = 0;

    logic [31:0] vtab    [0:3] = '{32'h04030201, 32'h14131211, 32'h24232221, 32'h34333231};
    logic [31:0] exp_k3  [0:5] = '{32'h00000001, 32'h00000211, 32'h00031221,
                                   32'h04132200, 32'h14230000, 32'h24000000};
    logic [31:0] exp_k1  [0:3] = '{32'h00000031, 32'h00003200, 32'h00330000, 32'h34000000};
    logic [7:0]  exp_n1  [0:1] = '{8'h5A, 8'hA5};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (shift_o) begin
            q_lane.push_back(lane_data_o);
            q_cyc.push_back(cyc);
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (shift1) begin
            q1_lane.push_back(lane1);
            q1_cyc.push_back(cyc);
        end
        if (done1) begin
            done1_cnt++;
            done1_cyc = cyc;
        end
    end

    task automatic clear_mon();
        q_lane.delete();
        q_cyc.delete();
    endtask

    task automatic feed(input int k, input int first, input int nvec, input int stall,
                        input bit poke, output bit to);
        to = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1;
        k_len_i = KW'(k);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int v = 0; v < nvec; v++) begin
            int g;
            g = 0;
            in_data_i  = vtab[first + v];
            in_valid_i = 1'b1;
            if (poke && v == 1) begin
                start_i = 1'b1;
                k_len_i = 5'd5;
            end
            while (!in_ready_o && g < 20) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 20) to = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            if (stall > 0 && v == 0) begin
                in_valid_i = 1'b0;
                repeat (stall) begin
                    @(posedge clk); #1;
                end
            end
        end
        in_valid_i = 1'b0;
        in_data_i  = '0;
    endtask

    task automatic wait_done(input int d0, output bit to);
        int g;
        g = 0;
        while (done_cnt == d0 && g < 60) begin
            @(posedge clk); #1;
            g++;
        end
        to = (done_cnt == d0);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        start_i    = 1'b0;
        k_len_i    = '0;
        in_data_i  = '0;
        in_valid_i = 1'b0;
        start1     = 1'b0;
        k1         = '0;
        data1      = '0;
        valid1     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (shift_o !== 1'b0) $display("FAIL reset_shift got %b want 0", shift_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
        n_total++; if (done_o !== 1'b0) $display("FAIL reset_done got %b want 0", done_o); else n_pass++;
        n_total++; if (in_ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", in_ready_o); else n_pass++;
        n_total++; if (lane_data_o !== 32'h0) $display("FAIL reset_lane got %h want 0", lane_data_o); else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit to_f, to_d;
        int d0;
        logic [31:0] got;
        clear_mon();
        d0 = done_cnt;
        feed(3, 0, 3, 0, 1'b0, to_f);
        wait_done(d0, to_d);
        n_total++; if (to_f || to_d) $display("FAIL basic_timeout got %b%b want 00", to_f, to_d); else n_pass++;
        n_total++; if (q_lane.size() !== 6) $display("FAIL basic_pulses got %0d want 6", q_lane.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            got = (i < q_lane.size()) ? q_lane[i] : 32'hxxxxxxxx;
            n_total++; if (got !== exp_k3[i]) $display("FAIL basic_step%0d got %h want %h", i + 1, got, exp_k3[i]); else n_pass++;
        end
        n_total++;
        if (q_cyc.size() == 0 || done_cyc != q_cyc[q_cyc.size() - 1] + 1)
            $display("FAIL basic_done_timing got done@%0d last_shift@%0d want one after", done_cyc,
                     (q_cyc.size() > 0) ? q_cyc[q_cyc.size() - 1] : -1);
        else n_pass++;
        n_total++; if (done_cnt - d0 != 1) $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (busy_o !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_stall();
        bit to_f, to_d;
        int d0;
        logic [31:0] got;
        clear_mon();
        d0 = done_cnt;
        feed(3, 0, 3, 2, 1'b0, to_f);
        wait_done(d0, to_d);
        n_total++; if (to_f || to_d) $display("FAIL stall_timeout got %b%b want 00", to_f, to_d); else n_pass++;
        n_total++; if (q_lane.size() !== 6) $display("FAIL stall_pulses got %0d want 6", q_lane.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            got = (i < q_lane.size()) ? q_lane[i] : 32'hxxxxxxxx;
            n_total++; if (got !== exp_k3[i]) $display("FAIL stall_step%0d got %h want %h", i + 1, got, exp_k3[i]); else n_pass++;
        end
        n_total++;
        if (q_cyc.size() < 2 || q_cyc[1] - q_cyc[0] != 3)
            $display("FAIL stall_gap got %0d want 3", (q_cyc.size() >= 2) ? q_cyc[1] - q_cyc[0] : -1);
        else n_pass++;
`ifdef MATRIX_SKEW_FEEDER_STALL_CNT_EN
        n_total++; if (stall_cnt_o !== 16'd2) $display("FAIL stall_cnt got %0d want 2", stall_cnt_o); else n_pass++;
`endif
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_zero_k();
        bit to_d;
        int d0, sc;
        clear_mon();
        d0 = done_cnt;
        @(posedge clk); #1;
        start_i = 1'b1;
        k_len_i = 5'd0;
        sc = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(d0, to_d);
        n_total++; if (q_lane.size() !== 0) $display("FAIL zero_pulses got %0d want 0", q_lane.size()); else n_pass++;
        n_total++;
        if (to_d || done_cyc > sc + 3)
            $display("FAIL zero_done_latency got %0d cycles want <=2 (timeout %b)", done_cyc - sc - 1, to_d);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (busy_o !== 1'b0) $display("FAIL zero_busy_end got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_restart_ignored();
        bit to_f, to_d;
        int d0;
        logic [31:0] got;
        clear_mon();
        d0 = done_cnt;
        feed(3, 0, 3, 0, 1'b1, to_f);
        wait_done(d0, to_d);
        n_total++; if (to_f || to_d) $display("FAIL restart_timeout got %b%b want 00", to_f, to_d); else n_pass++;
        n_total++; if (q_lane.size() !== 6) $display("FAIL restart_pulses got %0d want 6", q_lane.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            got = (i < q_lane.size()) ? q_lane[i] : 32'hxxxxxxxx;
            n_total++; if (got !== exp_k3[i]) $display("FAIL restart_step%0d got %h want %h", i + 1, got, exp_k3[i]); else n_pass++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        bit to_f, to_d;
        int d0;
        logic [31:0] got;
        clear_mon();
        d0 = done_cnt;
        @(posedge clk); #1;
        start_i = 1'b1;
        k_len_i = 5'd3;
        @(posedge clk); #1;
        start_i    = 1'b0;
        in_data_i  = vtab[0];
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_data_i = vtab[1];
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        reset_n    = 1'b0;
        #1;
        n_total++; if (shift_o !== 1'b0) $display("FAIL abort_shift got %b want 0", shift_o); else n_pass++;
        n_total++; if (lane_data_o !== 32'h0) $display("FAIL abort_lane got %h want 0", lane_data_o); else n_pass++;
        n_total++;
        if (busy_o !== 1'b0 || in_ready_o !== 1'b0)
            $display("FAIL abort_busy_ready got %b%b want 00", busy_o, in_ready_o);
        else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (done_cnt != d0) $display("FAIL abort_no_done got %0d want 0", done_cnt - d0); else n_pass++;
        clear_mon();
        d0 = done_cnt;
        feed(1, 3, 1, 0, 1'b0, to_f);
        wait_done(d0, to_d);
        n_total++; if (to_f || to_d) $display("FAIL abort_timeout got %b%b want 00", to_f, to_d); else n_pass++;
        n_total++; if (q_lane.size() !== 4) $display("FAIL abort_pulses got %0d want 4", q_lane.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            got = (i < q_lane.size()) ? q_lane[i] : 32'hxxxxxxxx;
            n_total++; if (got !== exp_k1[i]) $display("FAIL abort_step%0d got %h want %h", i + 1, got, exp_k1[i]); else n_pass++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_n1();
        int d0, g;
        logic [7:0] got;
        q1_lane.delete();
        q1_cyc.delete();
        d0 = done1_cnt;
        @(posedge clk); #1;
        start1 = 1'b1;
        k1     = 5'd2;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int v = 0; v < 2; v++) begin
            data1  = exp_n1[v];
            valid1 = 1'b1;
            g = 0;
            while (!ready1 && g < 20) begin
                @(posedge clk); #1;
                g++;
            end
            @(posedge clk); #1;
        end
        valid1 = 1'b0;
        data1  = '0;
        g = 0;
        while (done1_cnt == d0 && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        n_total++; if (done1_cnt - d0 != 1) $display("FAIL n1_done_count got %0d want 1", done1_cnt - d0); else n_pass++;
        n_total++; if (q1_lane.size() !== 2) $display("FAIL n1_pulses got %0d want 2", q1_lane.size()); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            got = (i < q1_lane.size()) ? q1_lane[i] : 8'hxx;
            n_total++; if (got !== exp_n1[i]) $display("FAIL n1_step%0d got %h want %h", i + 1, got, exp_n1[i]); else n_pass++;
        end
        n_total++;
        if (q1_cyc.size() == 0 || done1_cyc != q1_cyc[q1_cyc.size() - 1] + 1)
            $display("FAIL n1_done_timing got done@%0d last_shift@%0d want one after", done1_cyc,
                     (q1_cyc.size() > 0) ? q1_cyc[q1_cyc.size() - 1] : -1);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (busy1 !== 1'b0) $display("FAIL n1_busy_end got %b want 0", busy1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_k();
        test_restart_ignored();
        test_reset_abort();
        test_n1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/matrix_skew_feeder.md
Name: matrix_skew_feeder

Overview:
Upstream operand stage of the systolic matrix multiplier. Accepts K operand vectors of N elements over a valid/ready handshake and re-times them into N diagonally skewed lanes: lane i is delayed by i shift steps. After the last vector it appends N-1 zero flush steps. It drives the per-lane shift-FIFO chain feeding the PE array, producing data plus a common shift strobe.

Parameters:
DATA_WIDTH, 8, width of one matrix element
N, 4, number of lanes (array dimension), >= 1
K_MAX, 16, maximum vectors per operation
KW, $clog2(K_MAX+1), width of the vector-count input (derived, localparam)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start_i  input  1  start operation; sampled only in IDLE
k_len_i  input  KW  number of vectors K for this operation, sampled with start_i
in_data_i  input  N*DATA_WIDTH  operand vector; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_valid_i  input  1  in_data_i valid
in_ready_o  output  1  feeder accepts a vector this cycle
lane_data_o  output  N*DATA_WIDTH  skewed lane outputs, same packing as in_data_i
shift_o  output  1  lane_data_o holds a new step; drives downstream FIFO shift inputs
busy_o  output  1  operation in progress
done_o  output  1  one-cycle pulse at end of operation

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; all skew registers 0; counters 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: in_ready_o=0. start_i=1 with k_len_i>=1: latch K, clear skew registers, go LOAD. start_i=1 with k_len_i=0: go DONE directly, no shifts. k_len_i>K_MAX: clamp to K_MAX.
- LOAD: in_ready_o=1 combinationally. Beat accepted when in_valid_i && in_ready_o. On each beat the skew pipeline advances one step. After the K-th beat: go DRAIN (N>1) or DONE (N=1).
- in_valid_i low in LOAD: stall; no advance; shift_o=0 next cycle; skew contents hold.
- DRAIN: exactly N-1 cycles; each advances one step with zero input elements; in_ready_o=0. Then DONE.
- DONE: done_o=1 for this single cycle, then IDLE.
- busy_o: 1 in LOAD, DRAIN and DONE; 0 in IDLE.
- Outputs are registered. A step in cycle t shows in cycle t+1 as shift_o=1, and lane_data_o is updated in that same cycle. lane_data_o holds its value when shift_o=0.
- Lane i in step s (1-based) carries element i of vector s-i. It is 0 when s-i<1 or s-i>K.
- Total shift_o pulses per operation: K+N-1. done_o is asserted in the cycle after the final shift_o pulse or later, never in the same cycle.
- start_i while busy_o=1: ignored.
- reset_n asserted mid-operation: immediate abort to reset values; no done_o.
- No arithmetic beyond counters. Step counter width is $clog2(K_MAX+N). Counters never wrap within one operation.

Optional Feature:
Macro: MATRIX_SKEW_FEEDER_STALL_CNT_EN.
- Defined: adds output port stall_cnt_o (16 bits). It counts LOAD cycles with in_valid_i=0, saturates at 16'hFFFF, clears on an accepted start_i, resets to 0, and holds its value in IDLE.
- Undefined: port and counter absent; the block is otherwise identical.

Decomposition:
- Shared package matrix_pkg holds:
  - the state enum feeder_state_t (IDLE, LOAD, DRAIN, DONE);
  - the default DATA_WIDTH constant;
  - a function for the lane-slice index.
- Sub-module skew_delay_line (params DATA_WIDTH, DELAY): DELAY-stage register chain with enable (advance), synchronous clear, async reset_n. It is instantiated per lane with DELAY=i; DELAY=0 is a pass-through to the output register.

Test Plan:
- N=4, K=3, vectors A=(01,02,03,04), B=(11,12,13,14), C=(21,22,23,24), in_valid_i always 1 -> exactly 6 shift_o pulses:
  - lane0 = 01,11,21,00,00,00
  - lane1 = 00,02,12,22,00,00
  - lane3 = 00,00,00,04,14,24
  - done_o one cycle after the last pulse.
- Same stimulus with in_valid_i low for 2 cycles between A and B -> identical lane sequence; no shift_o during the stall; with the macro defined, stall_cnt_o=2.
- k_len_i=0 start -> no shift_o, done_o pulse within 2 cycles, busy_o back to 0.
- start_i pulsed again during LOAD with k_len_i=5 -> ignored; operation completes with K=3 (6 pulses).
- reset_n low after 2 accepted beats -> all outputs 0 immediately, state IDLE; a new K=1 operation then gives 4 pulses with lane0 first = element0 and earlier data absent.
- N=1, K=2 -> 2 pulses, no DRAIN, done_o follows.
